ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB slave (responder) on the far side of ahb_decoder: consumes one HSEL_Sx plus the shared
//  master address/control bus, and returns the HRDATA_Sx/HRESP_Sx/HREADY_Sx that the decoder muxes.
//  Backs a word-addressed, byte-writable on-chip SRAM. Zero or fixed wait states; two-cycle ERROR response.
// PARAMETERS
//  MEM_WORDS    1024  SRAM depth in 32-bit words (power of 2); byte range = MEM_WORDS*4
//  WAIT_CYCLES  1     wait states per data phase when AHB_SRAM_WAIT_EN is defined (1..15)
// PORTS
//  HCLK       in   1   bus clock
//  HRESET     in   1   synchronous, active-high reset
//  HSEL       in   1   slave select from ahb_decoder
//  HADDR      in   32  address (`AHB_ADDR_WIDTH); offset = HADDR[log2(MEM_WORDS*4)-1:0]
//  HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ
//  HWRITE     in   1   1=write
//  HSIZE      in   3   0=byte 1=half 2=word
//  HWDATA     in   32  write data, valid in data phase
//  HREADY     in   1   bus-level HREADY (decoder HREADY_S fed back)
//  HRDATA     out  32  read data to decoder
//  HRESP      out  2   OKAY/ERROR
//  HREADY_OUT out  1   slave ready to decoder
// BEHAVIOUR
//  - Reset: HREADY_OUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE; SRAM contents not cleared. Reset wins over
//    any in-flight transfer; a write whose final cycle coincides with HRESET is not committed.
//  - Accept: HSEL & HTRANS[1] & HREADY at posedge -> register HADDR, HWRITE, HSIZE. IDLE/BUSY or
//    HSEL=0 -> no access, next cycle OKAY with HREADY_OUT=1.
//  - Error check at accept: HSIZE>2, half with HADDR[0]=1, word with HADDR[1:0]!=0, or offset beyond
//    MEM_WORDS*4 (HADDR upper bits ignored = aliasing NOT allowed; flagged via ADDR_LIMIT check).
//  - FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//    IDLE/DATA --accept ok--> WAIT (macro on) or DATA (macro off); --accept err--> ERR1; else IDLE.
//    WAIT: HREADY_OUT=0, HRESP=OKAY; down-counter from WAIT_CYCLES-1; at 0 -> DATA.
//    DATA: HREADY_OUT=1, HRESP=OKAY; write commits at this edge using HWDATA with byte enables from
//          HSIZE/HADDR[1:0]; read drives HRDATA = mem[addr_q] (combinational), other cycles HRDATA=0.
//          A new accept in DATA is a back-to-back pipelined transfer (no bubble).
//    ERR1: HREADY_OUT=0, HRESP=ERROR -> ERR2. ERR2: HREADY_OUT=1, HRESP=ERROR; no memory write;
//          HRDATA=0; next address phase may be accepted in ERR2 (master may also cancel with IDLE).
//  - Byte lanes little-endian: byte n -> HWDATA[8n+7:8n]; half at HADDR[1]=1 -> [31:16].
//  - Read-after-write same address, back-to-back: read returns new data (write commits before read phase).
//  - Latency: zero-wait build = 1 data cycle; wait build = WAIT_CYCLES+1 data cycles.
// CONFIGURATION
//  - AHB_SRAM_WAIT_EN defined: WAIT state and counter present, WAIT_CYCLES wait states every transfer.
//  - Not defined: WAIT state and counter removed, WAIT_CYCLES ignored, all OKAY transfers zero-wait.
//  - ERROR path identical in both builds.
// STRUCTURE
//  - ahb_defines.vh (shared): add `BUSY, `NONSEQ, `SEQ, `ERROR, `SIZE_BYTE/HALF/WORD beside existing
//    `IDLE, `OKAY, `AHB_ADDR_WIDTH, `AHB_DATA_WIDTH. FSM state encodings stay local.
//  - Sub-module ahb_sram_mem: MEM_WORDS x 32 array, 4-bit byte write enable, async read port.
// TESTING
//  1 Reset then idle: HRESET=1 2 cycles -> HREADY_OUT=1, HRESP=00, HRDATA=0; HTRANS=IDLE with HSEL=1 -> OKAY, no access.
//  2 Word write 0x12345678 @0x10 then word read @0x10 back-to-back -> HRDATA=0x12345678, OKAY, zero-wait
//    (macro off) / HREADY_OUT low exactly WAIT_CYCLES cycles each (macro on).
//  3 Byte write 0xAB @0x11 over word 0x00000000 -> word read @0x10 = 0x0000AB00; half write 0xBEEF @0x12 -> 0xBEEFAB00.
//  4 Word write @0x02 (unaligned) -> HRESP=ERROR with HREADY_OUT 0 then 1; following read @0x00 shows memory unchanged.
//  5 Access @offset MEM_WORDS*4 and HSIZE=3 -> two-cycle ERROR each; no write.
//  6 HRESET asserted in the DATA cycle of a write 0xFFFFFFFF @0x20 -> outputs reset next cycle; read @0x20 returns old value.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - AHB bus encodings and byte-lane helper shared by the SRAM slave and its bench
package ahb_sram_slave_pkg;

    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    // Little-endian lane enables; only called for already-validated sizes/alignments.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: byte_enable = 4'b0001 << lo;
            SIZE_HALF: byte_enable = lo[1] ? 4'b1100 : 4'b0011;
            default:   byte_enable = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// rtl/ahb_sram_mem.sv - MEM_WORDS x 32 SRAM array with per-byte write enables and asynchronous read
module ahb_sram_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB SRAM responder with two-cycle ERROR response
// Define AHB_SRAM_WAIT_EN to insert WAIT_CYCLES wait states before every OKAY data phase.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSEL,
    input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic                      HREADY,
    output logic [AHB_DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]                HRESP,
    output logic                      HREADY_OUT
);

    localparam int OFF_W = $clog2(MEM_WORDS * 4);

`ifdef AHB_SRAM_WAIT_EN
    localparam int WAIT_STATES = WAIT_CYCLES;
`else
    // Wait states compiled out: every OKAY transfer goes straight to DATA.
    localparam int WAIT_STATES = WAIT_CYCLES * 0;
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_e;

    state_e           state_q, state_d;
    logic [OFF_W-1:0] addr_q, addr_d;
    logic             write_q, write_d;
    logic [2:0]       size_q, size_d;
    logic             hready_q, hready_d;
    logic [1:0]       hresp_q, hresp_d;
`ifdef AHB_SRAM_WAIT_EN
    logic [3:0]       cnt_q, cnt_d;
`endif

    logic        accept;
    logic        addr_err;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    // Upper address bits must be zero: the SRAM does not alias across its window.
    assign addr_err = (HSIZE > SIZE_WORD)
                   || ((HSIZE == SIZE_HALF) && HADDR[0])
                   || ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00))
                   || (HADDR[AHB_ADDR_WIDTH-1:OFF_W] != '0);

    assign accept = HSEL && HTRANS[1] && HREADY
                 && (state_q inside {ST_IDLE, ST_DATA, ST_ERR2});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
`ifdef AHB_SRAM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_WAIT: begin
`ifdef AHB_SRAM_WAIT_EN
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
`else
                state_d = ST_DATA;
`endif
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    addr_d  = HADDR[OFF_W-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = (WAIT_STATES != 0) ? ST_WAIT : ST_DATA;
                    end
`ifdef AHB_SRAM_WAIT_EN
                    cnt_d = 4'(WAIT_STATES - 1);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        hready_d = !(state_d inside {ST_WAIT, ST_ERR1});
        hresp_d  = (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= SIZE_BYTE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
`ifdef AHB_SRAM_WAIT_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
`ifdef AHB_SRAM_WAIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Reset in the final data cycle suppresses the commit.
    assign mem_we = (state_q == ST_DATA && write_q && !HRESET)
                  ? byte_enable(size_q, addr_q[1:0]) : 4'b0000;

    ahb_sram_mem #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .addr  (addr_q[OFF_W-1:2]),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HRDATA     = (state_q == ST_DATA && !write_q) ? mem_rdata : '0;
    assign HRESP      = hresp_q;
    assign HREADY_OUT = hready_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized self-checking bench for ahb_sram_slave against a byte-array model
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam int MEM_WORDS   = 1024;
    localparam int WAIT_CYCLES = 2;
`ifdef AHB_SRAM_WAIT_EN
    localparam int EXP_WAITS = WAIT_CYCLES;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        hready_out;

    always #5 clk = ~clk;

    ahb_sram_slave #(
        .MEM_WORDS   (MEM_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .HCLK       (clk),
        .HRESET     (rst),
        .HSEL       (hsel),
        .HADDR      (haddr),
        .HTRANS     (htrans),
        .HWRITE     (hwrite),
        .HSIZE      (hsize),
        .HWDATA     (hwdata),
        .HREADY     (hready_out),
        .HRDATA     (hrdata),
        .HRESP      (hresp),
        .HREADY_OUT (hready_out)
    );

    typedef struct {
        bit          write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
        bit          has_exp;
        logic [31:0] exp;
    } op_t;

    op_t         ops_q[$];
    logic [31:0] model [MEM_WORDS];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input op_t o);
        if (o.size > 3'd2) return 1'b1;
        if ((o.addr % (32'd1 << o.size)) != 0) return 1'b1;
        if (o.addr >= 32'(MEM_WORDS * 4)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void push(input bit w, input logic [2:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, input int gap,
                                 input bit has_exp = 1'b0, input logic [31:0] exp = 32'h0);
        op_t o;
        o.write = w; o.size = sz; o.addr = a; o.wdata = d; o.gap = gap;
        o.has_exp = has_exp; o.exp = exp;
        ops_q.push_back(o);
    endfunction

    task automatic drive_idle();
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
            0: begin hsel = 1'b0; htrans = HTRANS_IDLE;   end
            1: begin hsel = 1'b1; htrans = HTRANS_IDLE;   end
            2: begin hsel = 1'b1; htrans = HTRANS_BUSY;   end
            default: begin hsel = 1'b0; htrans = HTRANS_NONSEQ; end
        endcase
    endtask

    task automatic drive_addr(input op_t o);
        hsel   = 1'b1;
        htrans = $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        haddr  = o.addr;
        hwrite = o.write;
        hsize  = o.size;
    endtask

    task automatic finish_op(input op_t o, input int lows, input logic [1:0] resp_low);
        if (is_err(o)) begin
            check_eq("err_low_cycles", 32'(lows), 32'd1);
            check_eq("err_first_resp", 32'(resp_low), 32'(HRESP_ERROR));
            check_eq("err_final_resp", 32'(hresp), 32'(HRESP_ERROR));
            check_eq("err_rdata", hrdata, 32'h0);
        end else begin
            check_eq("ok_wait_cycles", 32'(lows), 32'(EXP_WAITS));
            check_eq("ok_resp", 32'(hresp), 32'(HRESP_OKAY));
            if (o.write) begin
                for (int a = int'(o.addr); a < int'(o.addr) + (1 << o.size); a++) begin
                    model[a / 4][8 * (a % 4) +: 8] = o.wdata[8 * (a % 4) +: 8];
                end
            end else begin
                check_eq($sformatf("rd_data@%0h", o.addr), hrdata, model[o.addr / 4]);
                if (o.has_exp) check_eq($sformatf("rd_expect@%0h", o.addr), hrdata, o.exp);
            end
        end
    endtask

    // Issues queued transfers; the next address phase overlaps the last cycle of the current data phase.
    task automatic run_seq();
        op_t        cur, nxt;
        bit         busy = 1'b0;
        bit         started = 1'b0;
        int         lows = 0;
        logic [1:0] resp_low = 2'b00;
        int         budget = 0;
        @(negedge clk);
        while ((ops_q.size() > 0 || busy || started) && budget < 20000) begin
            budget++;
            if (busy) begin
                if (hready_out) begin
                    finish_op(cur, lows, resp_low);
                    busy = 1'b0;
                end else begin
                    if (lows == 0) resp_low = hresp;
                    lows++;
                end
            end
            if (!busy && ops_q.size() > 0 && ops_q[0].gap == 0) begin
                nxt = ops_q.pop_front();
                drive_addr(nxt);
                started = 1'b1;
            end else begin
                if (!busy && ops_q.size() > 0) begin
                    nxt = ops_q[0];
                    nxt.gap--;
                    ops_q[0] = nxt;
                end
                drive_idle();
            end
            @(posedge clk);
            #1;
            if (started) begin
                cur = nxt; busy = 1'b1; started = 1'b0;
                lows = 0; resp_low = 2'b00;
                hwdata = cur.wdata;
            end
            @(negedge clk);
        end
        if (budget >= 20000) begin
            check_eq("seq_pending_at_timeout", 32'(ops_q.size()) + 32'(busy), 32'h0);
            ops_q.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; hsel = 1'b1; htrans = HTRANS_IDLE; haddr = 32'h0;
        hwrite = 1'b0; hsize = SIZE_WORD; hwdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_hready", 32'(hready_out), 32'd1);
        check_eq("reset_hresp", 32'(hresp), 32'(HRESP_OKAY));
        check_eq("reset_hrdata", hrdata, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_hready", 32'(hready_out), 32'd1);
            check_eq("idle_hresp", 32'(hresp), 32'(HRESP_OKAY));
            check_eq("idle_hrdata", hrdata, 32'h0);
        end

        for (int w = 0; w < MEM_WORDS; w++) push(1'b1, SIZE_WORD, 32'(w * 4), $urandom, 0);
        run_seq();

        push(1'b1, SIZE_WORD, 32'h10, 32'h12345678, 0);
        push(1'b0, SIZE_WORD, 32'h10, 32'h0, 0, 1'b1, 32'h12345678);
        push(1'b1, SIZE_WORD, 32'h10, 32'h00000000, 1);
        push(1'b1, SIZE_BYTE, 32'h11, 32'h0000AB00, 0);
        push(1'b0, SIZE_WORD, 32'h10, 32'h0, 0, 1'b1, 32'h0000AB00);
        push(1'b1, SIZE_HALF, 32'h12, 32'hBEEF0000, 0);
        push(1'b0, SIZE_WORD, 32'h10, 32'h0, 0, 1'b1, 32'hBEEFAB00);
        push(1'b1, SIZE_WORD, 32'h00, 32'hCAFEF00D, 1);
        push(1'b1, SIZE_WORD, 32'h02, 32'h11111111, 0);
        push(1'b0, SIZE_WORD, 32'h00, 32'h0, 0, 1'b1, 32'hCAFEF00D);
        push(1'b1, SIZE_WORD, 32'(MEM_WORDS * 4), 32'hDEADBEEF, 0);
        push(1'b1, 3'd3, 32'h00, 32'h22222222, 0);
        push(1'b0, SIZE_WORD, 32'(MEM_WORDS * 4), 32'h0, 0);
        push(1'b0, SIZE_WORD, 32'h00, 32'h0, 0, 1'b1, 32'hCAFEF00D);
        push(1'b1, SIZE_WORD, 32'h20, 32'h55AA55AA, 0);
        run_seq();

        @(negedge clk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = SIZE_WORD;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        k = 0;
        while (!hready_out && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_write_wait_cycles", 32'(k), 32'(EXP_WAITS));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_hready", 32'(hready_out), 32'd1);
        check_eq("rst_mid_hresp", 32'(hresp), 32'(HRESP_OKAY));
        check_eq("rst_mid_hrdata", hrdata, 32'h0);
        rst = 1'b0;
        push(1'b0, SIZE_WORD, 32'h20, 32'h0, 0, 1'b1, 32'h55AA55AA);
        run_seq();

        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic [2:0]  sz;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            sz  = 3'($urandom_range(0, 2));
            a   = 32'($urandom_range(0, 255));
            if (sel == 0) sz = 3'd3;
            else if (sel == 1) a = 32'(MEM_WORDS * 4) + (a & ~32'h3);
            else if (sel == 2) a = a | 32'h8000_0000;
            else if (sel >= 4) a = a & ~((32'd1 << sz) - 32'd1);
            push(1'($urandom_range(0, 1)), sz, a, $urandom,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        run_seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
